serial_add32_ctrl: RTL and testbench

SERIAL_ADD32_CTRL -- requirements
Module: serial_add32_ctrl

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/add8_slice.sv | 28 ++
 rtl/serial_add32_ctrl.sv | 114 +++++++++++
 tb/tb_serial_add32_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the byte-serial adder.
package serial_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add8_slice.sv
// Combinational 8-bit ripple-carry adder slice; c7 is the carry into the top bit.
module add8_slice
  import serial_add_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  input  logic              i_cin,
  output logic [BYTE_W-1:0] o_sum,
  output logic              o_cout,
  output logic              o_c7
);

  logic [BYTE_W:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < BYTE_W; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout = w_c[BYTE_W];
  assign o_c7   = w_c[BYTE_W-1];

endmodule

// File: rtl/serial_add32_ctrl.sv
// Byte-serial adder: one shared 8-bit slice, LSB first, registered inter-byte carry.
// Optional subtraction (sub port) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add32_ctrl
  import serial_add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;

  logic [BYTE_W-1:0]  w_a_byte;
  logic [BYTE_W-1:0]  w_b_byte;
  logic [BYTE_W-1:0]  w_sum_byte;
  logic               w_cout;
  logic               w_c7;
  logic [IDX_W+2:0]   w_bit_ofs;

  // byte index scaled to a bit offset (idx * 8)
  assign w_bit_ofs = {r_idx, 3'b000};
  assign w_a_byte  = r_a[w_bit_ofs +: BYTE_W];
  assign w_b_byte  = r_b[w_bit_ofs +: BYTE_W];

  add8_slice u_slice (
    .i_a    (w_a_byte),
    .i_b    (w_b_byte),
    .i_cin  (r_carry),
    .o_sum  (w_sum_byte),
    .o_cout (w_cout),
    .o_c7   (w_c7)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_idx <= '0;
`ifdef SERIAL_ADD_SUB_EN
            // subtraction is A + ~B + 1; the +1 rides in on the initial carry
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
`else
            r_b     <= b;
            r_carry <= cin;
`endif
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum[w_bit_ofs +: BYTE_W] <= w_sum_byte;
          r_carry                    <= w_cout;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_cout;
            r_ovf   <= w_c7 ^ w_cout;
            r_idx   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_add32_ctrl.sv
// Directed bench for serial_add32_ctrl with NBYTES=4 and hand-computed results.
module tb_serial_add32_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
`ifdef SERIAL_ADD_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add32_ctrl #(.NBYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair from IDLE, wait for the result, check it, and retire it.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'd4);
    check_eq({tag, "_sum"}, 64'(sum), 64'(es));
    check_eq({tag, "_cout"}, 64'(cout), 64'(ec));
    check_eq({tag, "_ovf"}, 64'(ovf), 64'(eo));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ops_a [3];
    logic [31:0] ops_b [3];
    logic        ops_c [3];
    logic [31:0] exp_s [3];
    logic        exp_c [3];
    int nxt, nres, last_t, t, seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_sum", 64'(sum), 64'd0);
    check_eq("rst_cout", 64'(cout), 64'd0);
    check_eq("rst_ovf", 64'(ovf), 64'd0);

    run_op("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("cin",    32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0);
    run_op("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    // Backpressure in DONE with a competing request that must be ignored
    a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check_eq("bp_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a = 32'hAAAA_AAAA; b = 32'h1111_1111; in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      check_eq("bp_sum", 64'(sum), 64'h0000_0100);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp_taken", 64'(out_valid), 64'd0);
    check_eq("bp_sum_kept", 64'(sum), 64'h0000_0100);
    repeat (6) tick();
    check_eq("bp_no_queue_busy", 64'(busy), 64'd0);
    check_eq("bp_no_queue_sum", 64'(sum), 64'h0000_0100);

    // Reset during the second RUN cycle
    a = 32'h0102_0304; b = 32'h1010_1010; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_sum", 64'(sum), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check_eq("midrst_no_result", 64'(seen), 64'd0);

    // Reset wins over a simultaneous request
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check_eq("rst_prio_busy", 64'(busy), 64'd0);

    // Streaming with in_valid and out_ready held high
    ops_a[0] = 32'h0000_0001; ops_b[0] = 32'h0000_0002; ops_c[0] = 1'b0;
    exp_s[0] = 32'h0000_0003; exp_c[0] = 1'b0;
    ops_a[1] = 32'hFFFF_0000; ops_b[1] = 32'h0001_0000; ops_c[1] = 1'b1;
    exp_s[1] = 32'h0000_0001; exp_c[1] = 1'b1;
    ops_a[2] = 32'h0000_FFFF; ops_b[2] = 32'h0000_0001; ops_c[2] = 1'b0;
    exp_s[2] = 32'h0001_0000; exp_c[2] = 1'b0;
    nxt = 0; nres = 0; last_t = -1;
    out_ready = 1'b1;
    for (t = 0; t < 40; t++) begin
      if (out_valid && nres < 3) begin
        check_eq("stream_sum", 64'(sum), 64'(exp_s[nres]));
        check_eq("stream_cout", 64'(cout), 64'(exp_c[nres]));
        if (last_t >= 0) check_eq("stream_gap", 64'(t - last_t), 64'd6);
        last_t = t;
        nres++;
      end
      if (in_ready) begin
        if (nxt < 3) begin
          a = ops_a[nxt]; b = ops_b[nxt]; cin = ops_c[nxt]; in_valid = 1'b1;
          nxt++;
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("stream_count", 64'(nres), 64'd3);

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    run_op("sub_neg", 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_pos", 32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    sub = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
